// File: rtl/bcd_pkg.sv
// Shared types and constants for the serial BCD adder: digit type, FSM state
// encoding and the decimal-adjust constants.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bcd_state_t;

    localparam bcd_digit_t BCD_MAX  = 4'd9;
    localparam bcd_digit_t BCD_CORR = 4'd6;

    function automatic logic is_bad_digit(input bcd_digit_t d);
        return d > BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One BCD digit of addition with decimal adjust; purely combinational and
// shared by all digit positions of the serial adder.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  bcd_digit_t a,
    input  bcd_digit_t b,
    input  logic       cin,
    output bcd_digit_t sum,
    output logic       cout,
    output logic       invalid
);

    logic [4:0] z;

    always_comb begin
        z    = {1'b0, a} + {1'b0, b} + {4'b0000, cin};
        sum  = z[3:0];
        cout = 1'b0;
        // Adding 6 in 4-bit arithmetic yields (z+6) mod 16 directly.
        if (z > {1'b0, BCD_MAX}) begin
            sum  = z[3:0] + BCD_CORR;
            cout = 1'b1;
        end
        // b may be the 9's complement (9-b mod 16), which is above 9 exactly
        // when the original digit was, so checking it here is equivalent.
        invalid = is_bad_digit(a) || is_bad_digit(b);
    end

endmodule

// File: rtl/bcd_serial_adder.sv
// Digit-serial packed-BCD adder, one digit per clock, LSD first. Define
// BCD_SUB_EN to add the Sub port and the 9's-complement subtract path.
module bcd_serial_adder
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  In_valid,
    output logic                  In_ready,
    input  logic [4*DIGITS-1:0]   Addend,
    input  logic [4*DIGITS-1:0]   Augend,
    input  logic                  Carry_in,
`ifdef BCD_SUB_EN
    input  logic                  Sub,
`endif
    output logic [4*DIGITS-1:0]   Sum,
    output logic                  Carry_out,
    output logic                  Invalid,
    output logic                  Out_valid,
    input  logic                  Out_ready,
    output bcd_state_t            fsm_state
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both 1; Sum/Carry_out/Invalid hold while Out_valid=1 and Out_ready=0.

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    bcd_state_t            state_q, state_d;
    logic [4*DIGITS-1:0]   a_q, b_q, sum_q;
    logic [IW-1:0]         idx_q;
    logic                  carry_q, cout_q, inv_q;
    logic                  last_digit;
    bcd_digit_t            a_dig, b_dig, b_eff, d_sum;
    logic                  d_cout, d_inv;

`ifdef BCD_SUB_EN
    logic                  sub_q;
`endif

    assign In_ready   = (state_q == IDLE) && !Reset;
    assign Out_valid  = (state_q == DONE);
    assign Sum        = sum_q;
    assign Carry_out  = cout_q;
    assign Invalid    = inv_q;
    assign fsm_state  = state_q;
    assign last_digit = (idx_q == IW'(DIGITS - 1));

    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                a_dig = a_q[4*i +: 4];
                b_dig = b_q[4*i +: 4];
            end
        end
`ifdef BCD_SUB_EN
        b_eff = sub_q ? (BCD_MAX - b_dig) : b_dig;
`else
        b_eff = b_dig;
`endif
    end

    bcd_digit_add u_digit (
        .a       (a_dig),
        .b       (b_eff),
        .cin     (carry_q),
        .sum     (d_sum),
        .cout    (d_cout),
        .invalid (d_inv)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (In_valid)   state_d = RUN;
            RUN:     if (last_digit) state_d = DONE;
            DONE:    if (Out_ready)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            inv_q   <= 1'b0;
`ifdef BCD_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (In_valid) begin
                        a_q   <= Addend;
                        b_q   <= Augend;
                        idx_q <= '0;
                        inv_q <= 1'b0;
`ifdef BCD_SUB_EN
                        sub_q   <= Sub;
                        // Subtract starts with carry = !borrow_in.
                        carry_q <= Sub ? !Carry_in : Carry_in;
`else
                        carry_q <= Carry_in;
`endif
                    end
                end
                RUN: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (idx_q == IW'(i)) sum_q[4*i +: 4] <= d_sum;
                    end
                    carry_q <= d_cout;
                    inv_q   <= inv_q | d_inv;
                    if (last_digit) cout_q <= d_cout;
                    else            idx_q  <= idx_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_serial_adder.sv
// Bench for bcd_serial_adder (DIGITS=4): table vectors, random decimal
// vectors, back-pressure and mid-operation reset. BCD_SUB_EN adds subtract.
module tb_bcd_serial_adder;
    import bcd_pkg::*;

    localparam int D  = 4;
    localparam int W  = 4 * D;
    localparam int RW = W + 2;

    logic          Clock = 1'b0;
    logic          Reset;
    logic          In_valid;
    logic          In_ready;
    logic [W-1:0]  Addend, Augend;
    logic          Carry_in;
    logic          Sub;
    logic [W-1:0]  Sum;
    logic          Carry_out, Invalid, Out_valid, Out_ready;
    bcd_state_t    fsm_state;

    int checks   = 0;
    int failures = 0;
    logic [RW-1:0] exp_q[$];

    bcd_serial_adder #(.DIGITS(D)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .In_valid  (In_valid),
        .In_ready  (In_ready),
        .Addend    (Addend),
        .Augend    (Augend),
        .Carry_in  (Carry_in),
`ifdef BCD_SUB_EN
        .Sub       (Sub),
`endif
        .Sum       (Sum),
        .Carry_out (Carry_out),
        .Invalid   (Invalid),
        .Out_valid (Out_valid),
        .Out_ready (Out_ready),
        .fsm_state (fsm_state)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] sum;
        logic         cout;
        logic         inv;
        int           hold;
    } vec_t;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic longint from_bcd(input logic [W-1:0] v);
        longint r = 0;
        for (int i = D - 1; i >= 0; i--) r = r * 10 + longint'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] to_bcd(input longint v);
        logic [W-1:0] r = '0;
        longint t = v;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Decimal reference for well-formed operands.
    function automatic logic [RW-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic cin, input logic sub);
        longint m = 1;
        longint s;
        logic   c;
        for (int i = 0; i < D; i++) m = m * 10;
        if (sub) begin
            s = from_bcd(a) - from_bcd(b) - longint'(cin);
            c = (s >= 0);
            if (s < 0) s = s + m;
        end else begin
            s = from_bcd(a) + from_bcd(b) + longint'(cin);
            c = (s >= m);
            if (c) s = s - m;
        end
        return {to_bcd(s), c, 1'b0};
    endfunction

    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic cin, input logic sub, input logic [RW-1:0] exp, input int hold);
        int lat;
        logic [RW-1:0] held;
        logic [RW-1:0] want;
        @(negedge Clock);
        check({name, "_in_ready"}, 64'(In_ready), 64'd1);
        Addend   = a;
        Augend   = b;
        Carry_in = cin;
        Sub      = sub;
        In_valid = 1'b1;
        exp_q.push_back(exp);
        @(posedge Clock);
        #1;
        In_valid = 1'b0;
        Addend   = W'($urandom);
        Augend   = W'($urandom);
        Carry_in = 1'($urandom);
        Sub      = 1'($urandom);
        lat = 0;
        do begin
            @(negedge Clock);
            lat++;
            if (lat == 1) check({name, "_busy_ready"}, 64'(In_ready), 64'd0);
        end while (!Out_valid && lat < 20);
        if (!Out_valid) begin
            check({name, "_timeout"}, 64'(Out_valid), 64'd1);
            void'(exp_q.pop_front());
            return;
        end
        check({name, "_latency"}, 64'(lat), 64'(D + 1));
        held = {Sum, Carry_out, Invalid};
        In_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge Clock);
            check({name, "_hold_valid"}, 64'(Out_valid), 64'd1);
            check({name, "_hold_stable"}, 64'({Sum, Carry_out, Invalid}), 64'(held));
            check({name, "_hold_in_ready"}, 64'(In_ready), 64'd0);
        end
        In_valid  = 1'b0;
        Out_ready = 1'b1;
        if (exp_q.size() == 0) begin
            check({name, "_queue_empty"}, 64'd0, 64'd1);
        end else begin
            want = exp_q.pop_front();
            check({name, "_result"}, 64'({Sum, Carry_out, Invalid}), 64'(want));
        end
        @(posedge Clock);
        #1;
        Out_ready = 1'b0;
        @(negedge Clock);
        check({name, "_out_valid_drop"}, 64'(Out_valid), 64'd0);
        check({name, "_back_idle"}, 64'(fsm_state), 64'(IDLE));
    endtask

`ifdef BCD_SUB_EN
    localparam int NV = 8;
`else
    localparam int NV = 6;
`endif

    vec_t vecs[NV];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] ra, rb;
        logic         rc, rs;

        //          a         b         cin   sub   sum       cout  inv   hold
        vecs[0] = '{16'h9999, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0};
        vecs[1] = '{16'h1234, 16'h5678, 1'b1, 1'b0, 16'h6913, 1'b0, 1'b0, 3};
        vecs[2] = '{16'h00A0, 16'h0000, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b1, 0};
        vecs[3] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1};
        vecs[4] = '{16'h5000, 16'h5000, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 0};
        vecs[5] = '{16'h0000, 16'h000F, 1'b0, 1'b0, 16'h0015, 1'b0, 1'b1, 0};
`ifdef BCD_SUB_EN
        vecs[6] = '{16'h0100, 16'h0001, 1'b0, 1'b1, 16'h0099, 1'b1, 1'b0, 0};
        vecs[7] = '{16'h0001, 16'h0002, 1'b0, 1'b1, 16'h9999, 1'b0, 1'b0, 2};
`endif

        Reset     = 1'b1;
        In_valid  = 1'b0;
        Out_ready = 1'b0;
        Addend    = '0;
        Augend    = '0;
        Carry_in  = 1'b0;
        Sub       = 1'b0;
        repeat (2) @(negedge Clock);
        check("reset_in_ready", 64'(In_ready), 64'd0);
        Reset = 1'b0;
        @(negedge Clock);
        check("reset_state", 64'({Sum, Carry_out, Invalid, Out_valid}), 64'd0);
        check("reset_in_ready_after", 64'(In_ready), 64'd1);

        for (int i = 0; i < NV; i++) begin
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub,
                   {vecs[i].sum, vecs[i].cout, vecs[i].inv}, vecs[i].hold);
        end

        // Reset during the second RUN cycle aborts the operation.
        @(negedge Clock);
        Addend   = 16'h4321;
        Augend   = 16'h1111;
        Carry_in = 1'b0;
        Sub      = 1'b0;
        In_valid = 1'b1;
        @(posedge Clock);
        #1;
        In_valid = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        check("abort_in_run", 64'(fsm_state), 64'(RUN));
        Reset = 1'b1;
        check("abort_in_ready_in_reset", 64'(In_ready), 64'd0);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        @(negedge Clock);
        check("abort_idle", 64'(fsm_state), 64'(IDLE));
        check("abort_out_valid", 64'(Out_valid), 64'd0);
        check("abort_sum", 64'(Sum), 64'd0);
        check("abort_in_ready", 64'(In_ready), 64'd1);
        run_op("after_abort", 16'h2468, 16'h1357, 1'b0, 1'b0, {16'h3825, 1'b0, 1'b0}, 0);

        for (int n = 0; n < 10; n++) begin
            for (int i = 0; i < D; i++) begin
                ra[4*i +: 4] = 4'($urandom_range(0, 9));
                rb[4*i +: 4] = 4'($urandom_range(0, 9));
            end
            rc = 1'($urandom_range(0, 1));
`ifdef BCD_SUB_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            run_op($sformatf("rand%0d", n), ra, rb, rc, rs, model(ra, rb, rc, rs),
                   int'($urandom_range(0, 2)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bcd_serial_adder.md
BCD_SERIAL_ADDER -- requirements
Module: bcd_serial_adder

Interface
REQ-001 SHALL have parameter DIGITS, default 4, meaning the number of BCD digits per operand (legal range 1..16).
REQ-002 SHALL have port Clock, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset, input, 1 bit, synchronous active-high reset.
REQ-004 SHALL have port In_valid, input, 1 bit, meaning the operands are presented.
REQ-005 SHALL have port In_ready, output, 1 bit, meaning the block accepts operands this cycle.
REQ-006 SHALL have ports Addend and Augend, each an input of 4*DIGITS bits, packed BCD with the least significant digit in bits [3:0].
REQ-007 SHALL have port Carry_in, input, 1 bit: carry-in for add, borrow-in for subtract.
REQ-008 SHALL have port Sub, input, 1 bit, meaning subtract; present only with BCD_SUB_EN.
REQ-009 SHALL have port Sum, output, 4*DIGITS bits, packed BCD result.
REQ-010 SHALL have port Carry_out, output, 1 bit: decimal carry for add, not-borrow for subtract.
REQ-011 SHALL have port Invalid, output, 1 bit, meaning an operand digit was greater than 9.
REQ-012 SHALL have port Out_valid, output, 1 bit, meaning the result is presented.
REQ-013 SHALL have port Out_ready, input, 1 bit, meaning the consumer takes the result.

Function
REQ-014 SHALL implement an FSM with states IDLE, RUN and DONE; In_ready SHALL be 1 only in IDLE and SHALL be 0 while Reset is asserted.
REQ-015 SHALL make the IDLE->RUN transition when In_valid&&In_ready; it SHALL capture Addend, Augend, Carry_in and Sub and clear the digit index and Invalid.
REQ-016 SHALL process one digit per cycle in RUN, LSD first, in digit index 0..DIGITS-1; the digit carry is registered between cycles.
REQ-017 SHALL compute each digit as follows: binary z = a + b' + c (5 bits); if z > 9, the digit is (z+6) mod 16 with carry 1, else the digit is z with carry 0.
REQ-018 SHALL use b' = b in add mode; with Sub, b' = 9-b and initial c = !Carry_in, so the result is A-B-Carry_in in 10's complement, and Carry_out=1 iff no borrow.
REQ-019 SHALL make the RUN->DONE transition after digit DIGITS-1; the final carry goes to Carry_out and Out_valid=1 from the first DONE cycle. Latency is DIGITS+1 cycles from accept to Out_valid.
REQ-020 SHALL set Invalid, sticky for the operation, if any captured nibble of Addend or Augend is greater than 9; the result is still computed per REQ-017 and Invalid is valid with Out_valid.
REQ-021 SHALL hold Sum, Carry_out and Invalid stable while Out_valid=1 and Out_ready=0 (unbounded back-pressure).
REQ-022 SHALL make the DONE->IDLE transition when Out_ready=1; Out_valid drops the next cycle. No new accept occurs in the DONE cycle (In_ready=0).
REQ-023 SHALL work with DIGITS=1: RUN lasts exactly one cycle.
REQ-024 SHALL ignore In_valid, Addend and Augend outside IDLE; captured operands SHALL NOT change mid-operation.

Reset
REQ-025 SHALL, when Reset=1 at a rising edge, place the FSM in IDLE and set Sum=0, Carry_out=0, Invalid=0, Out_valid=0 and the digit index to 0.
REQ-026 SHALL abort any operation in RUN or DONE on Reset with no result delivered; Reset SHALL take priority over all other inputs.

Configuration
REQ-027 SHALL, with macro BCD_SUB_EN defined, provide the Sub port and the 9's-complement path per REQ-018.
REQ-028 SHALL, without BCD_SUB_EN, omit the Sub port and complement logic; the block is add-only and Carry_in is the carry-in.

Structure
REQ-029 SHALL place in shared package bcd_pkg: typedef bcd_digit_t (4 bits), the FSM state enum (IDLE/RUN/DONE), and constants BCD_MAX=9 and BCD_CORR=6.
REQ-030 SHALL contain one combinational sub-module, bcd_digit_add (a, b, cin -> sum, cout, invalid), instantiated once and time-shared across digits.

Verification
REQ-031 SHALL verify with DIGITS=4: 9999+0001, Carry_in=0 -> Sum=0000, Carry_out=1, Out_valid 5 cycles after the accept edge.
REQ-032 SHALL verify: 1234+5678, Carry_in=1 -> Sum=6913, Carry_out=0, Invalid=0.
REQ-033 SHALL verify with BCD_SUB_EN: 0100-0001 -> 0099, Carry_out=1; 0001-0002 -> 9999, Carry_out=0.
REQ-034 SHALL verify: Addend=00A0, Augend=0000 -> Invalid=1 with Out_valid; Invalid=0 on the next valid operation.
REQ-035 SHALL verify: Out_ready held 0 for 3 DONE cycles -> Sum, Carry_out and Out_valid are stable, and In_ready=0 throughout.
REQ-036 SHALL verify: Reset asserted in the 2nd RUN cycle -> next cycle IDLE, Out_valid=0, Sum=0, In_ready=1, and the next accepted operation is correct.
